apb_spi_read_ctrl: RTL and testbench

- APB-programmable read sequencer sitting directly upstream of spi_drive; replaces the fixed-parameter read controller.
- Software writes a 24-bit flash address and a byte count, then sets START. The block issues the command byte and three address bytes, then clocks dummy bytes and collects the returned data into an RX FIFO.
- Software drains the RX FIFO through an APB data register.

---
 rtl/apb_spi_pkg.sv | 45 ++++
 rtl/spi_rx_fifo.sv | 56 +++++
 rtl/apb_spi_read_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_apb_spi_read_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_spi_pkg.sv
// Shared definitions for the APB-programmable SPI flash read sequencer:
// register map, CTRL/STATUS bit positions, opcodes and FSM encoding.
package apb_spi_pkg;

  localparam int unsigned APB_AW   = 5;
  localparam int unsigned APB_DW   = 32;
  localparam int unsigned ADDR_W   = 24;
  localparam int unsigned LEN_W    = 8;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned ST_CNT_W = 5;

  localparam logic [APB_AW-1:0] REG_CTRL   = 5'h00;
  localparam logic [APB_AW-1:0] REG_ADDR   = 5'h04;
  localparam logic [APB_AW-1:0] REG_LEN    = 5'h08;
  localparam logic [APB_AW-1:0] REG_STATUS = 5'h0C;
  localparam logic [APB_AW-1:0] REG_RDATA  = 5'h10;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_CLR   = 1;

  localparam logic [BYTE_W-1:0] OP_READ      = 8'h03;
  localparam logic [BYTE_W-1:0] OP_FAST_READ = 8'h0B;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_AD2   = 3'd2,
    S_AD1   = 3'd3,
    S_AD0   = 3'd4,
    S_DUMMY = 3'd5,
    S_READ  = 3'd6,
    S_FIN   = 3'd7
  } state_t;

  // STATUS register layout as seen on prdata
  typedef struct packed {
    logic [18:0]         rsvd_hi;
    logic [ST_CNT_W-1:0] cnt;
    logic [4:0]          rsvd_lo;
    logic                ovf;
    logic                done;
    logic                busy;
  } status_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous byte FIFO with first-word-fall-through output and flush.
// Push on full and pop on empty are ignored.
module spi_rx_fifo
  import apb_spi_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [BYTE_W-1:0]        din,
  output logic [BYTE_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/apb_spi_read_ctrl.sv
// APB-programmable flash read sequencer driving spi_drive; received bytes
// land in an RX FIFO drained via RDATA. FAST_READ_EN selects 0x0B + dummy byte.
module apb_spi_read_ctrl
  import apb_spi_pkg::*;
#(
  parameter int unsigned       FIFO_DEPTH = 16,
  parameter logic [BYTE_W-1:0] RD_CMD     = OP_READ
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [APB_AW-1:0]   paddr,
  input  logic [APB_DW-1:0]   pwdata,
  output logic [APB_DW-1:0]   prdata,
  output logic                pready,
  output logic                pslverr,
  output logic                spi_start,
  output logic                spi_end,
  output logic [BYTE_W-1:0]   data_send,
  input  logic                send_done,
  input  logic [BYTE_W-1:0]   data_rec,
  input  logic                rec_done
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef FAST_READ_EN
  localparam logic [BYTE_W-1:0] OPCODE = OP_FAST_READ;
`else
  localparam logic [BYTE_W-1:0] OPCODE = RD_CMD;
`endif

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    rem_q;
  logic                done_q;
  logic                ovf_q;
  logic                spi_start_d;
  logic                spi_end_d;
  logic [BYTE_W-1:0]   data_send_d;

  logic                access;
  logic                addr_ok;
  logic                wr_acc;
  logic                rd_acc;
  logic                start_req;
  logic                clr_req;
  logic                start_go;
  logic                rx_byte;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [BYTE_W-1:0]   fifo_dout;
  logic [CNT_W-1:0]    fifo_count;
  status_t             status;

  // APB decode; only word-aligned offsets up to RDATA are mapped
  assign access    = psel & penable;
  assign addr_ok   = (paddr[1:0] == 2'b00) && (paddr <= REG_RDATA);
  assign wr_acc    = access & pwrite & addr_ok;
  assign rd_acc    = access & ~pwrite & addr_ok;
  assign pready    = 1'b1;
  assign pslverr   = access & ~addr_ok;
  assign start_req = wr_acc && (paddr == REG_CTRL) && pwdata[CTRL_START];
  assign clr_req   = wr_acc && (paddr == REG_CTRL) && pwdata[CTRL_CLR];
  assign start_go  = start_req && (state == S_IDLE);

  assign rx_byte   = (state == S_READ) && rec_done;
  assign fifo_push = rx_byte && !fifo_full;
  assign fifo_pop  = rd_acc && (paddr == REG_RDATA) && !fifo_empty;

  spi_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (clr_req),
    .din   (data_rec),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_go && (len_q != '0)) state_next = S_CMD;
      S_CMD:   if (send_done) state_next = S_AD2;
      S_AD2:   if (send_done) state_next = S_AD1;
      S_AD1:   if (send_done) state_next = S_AD0;
`ifdef FAST_READ_EN
      S_AD0:   if (send_done) state_next = S_DUMMY;
      S_DUMMY: if (send_done) state_next = S_READ;
`else
      S_AD0:   if (send_done) state_next = S_READ;
`endif
      S_READ:  if (rec_done && (rem_q == LEN_W'(1))) state_next = S_FIN;
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // SPI-side outputs are precomputed from the next state and then registered
  always_comb begin
    spi_start_d = (state == S_IDLE) && (state_next == S_CMD);
    spi_end_d   = (state != S_FIN) && (state_next == S_FIN);
    data_send_d = '0;
    case (state_next)
      S_CMD:   data_send_d = OPCODE;
      S_AD2:   data_send_d = addr_q[23:16];
      S_AD1:   data_send_d = addr_q[15:8];
      S_AD0:   data_send_d = addr_q[7:0];
      default: data_send_d = '0;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      spi_start <= 1'b0;
      spi_end   <= 1'b0;
      data_send <= '0;
    end else begin
      spi_start <= spi_start_d;
      spi_end   <= spi_end_d;
      data_send <= data_send_d;
    end
  end

  // Config registers are frozen while a transfer is active
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      addr_q <= '0;
      len_q  <= '0;
      rem_q  <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_acc && (state == S_IDLE) && (paddr == REG_ADDR)) addr_q <= pwdata[ADDR_W-1:0];
      if (wr_acc && (state == S_IDLE) && (paddr == REG_LEN))  len_q  <= pwdata[LEN_W-1:0];

      if (start_go)     rem_q <= len_q;
      else if (rx_byte) rem_q <= rem_q - LEN_W'(1);

      // CLR is applied before START is evaluated in the same write
      if (clr_req || start_go)                     done_q <= 1'b0;
      if ((start_go && (len_q == '0)) || spi_end_d) done_q <= 1'b1;

      if (clr_req)               ovf_q <= 1'b0;
      if (rx_byte && fifo_full)  ovf_q <= 1'b1;
    end
  end

  always_comb begin
    status      = '0;
    status.busy = (state != S_IDLE);
    status.done = done_q;
    status.ovf  = ovf_q;
    status.cnt  = ST_CNT_W'(fifo_count);
  end

  // Read mux is combinational; CTRL is write-only and reads back 0
  always_comb begin
    prdata = '0;
    if (psel) begin
      case (paddr)
        REG_ADDR:   prdata = {8'h00, addr_q};
        REG_LEN:    prdata = {24'h0, len_q};
        REG_STATUS: prdata = status;
        REG_RDATA:  prdata = fifo_empty ? '0 : {24'h0, fifo_dout};
        default:    prdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_spi_read_ctrl.sv
// Directed bench for apb_spi_read_ctrl with a hand-driven spi_drive model.
// Honours FAST_READ_EN for the expected opcode and dummy byte.
module tb_apb_spi_read_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [4:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        spi_start, spi_end;
  logic [7:0]  data_send;
  logic        send_done = 1'b0;
  logic [7:0]  data_rec = '0;
  logic        rec_done = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int n_start = 0;
  int n_end = 0;

`ifdef FAST_READ_EN
  localparam logic [7:0] EXP_OP = 8'h0B;
`else
  localparam logic [7:0] EXP_OP = 8'h03;
`endif

  apb_spi_read_ctrl #(.FIFO_DEPTH(16), .RD_CMD(8'h03)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .spi_start(spi_start), .spi_end(spi_end), .data_send(data_send),
    .send_done(send_done), .data_rec(data_rec), .rec_done(rec_done)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (spi_start) n_start++;
    if (spi_end)   n_end++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [4:0] a, input logic [31:0] d, output logic err);
    @(posedge sys_clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge sys_clk); #1;
    penable = 1'b1;
    #1 err = pslverr;
    @(posedge sys_clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic e;
    apb_write(a, d, e);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    @(posedge sys_clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge sys_clk); #1;
    penable = 1'b1;
    #1 d = prdata;
    @(posedge sys_clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Combinational look at prdata without an access phase
  task automatic peek(input logic [4:0] a, output logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    #1 d = prdata;
    psel = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse_send(output logic [7:0] seen);
    @(posedge sys_clk); #1;
    seen = data_send;
    send_done = 1'b1;
    @(posedge sys_clk); #1;
    send_done = 1'b0;
  endtask

  task automatic pulse_rec(input logic [7:0] b, output logic [7:0] seen);
    @(posedge sys_clk); #1;
    seen = data_send;
    data_rec = b; rec_done = 1'b1;
    @(posedge sys_clk); #1;
    rec_done = 1'b0;
  endtask

  task automatic send_header(input string tag, input logic [23:0] a);
    logic [7:0] s;
    pulse_send(s); check({tag, ".op"},  32'(s), 32'(EXP_OP));
    pulse_send(s); check({tag, ".ad2"}, 32'(s), 32'(a[23:16]));
    pulse_send(s); check({tag, ".ad1"}, 32'(s), 32'(a[15:8]));
    pulse_send(s); check({tag, ".ad0"}, 32'(s), 32'(a[7:0]));
`ifdef FAST_READ_EN
    pulse_send(s); check({tag, ".dummy"}, 32'(s), 32'h00);
`endif
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  s;
    logic        e;
    int          s0, e0;

    // Reset state
    idle(2);
    check("rst.spi_start", 32'(spi_start), 32'h0);
    check("rst.spi_end",   32'(spi_end),   32'h0);
    check("rst.data_send", 32'(data_send), 32'h0);
    check("rst.prdata",    prdata,         32'h0);
    check("rst.pslverr",   32'(pslverr),   32'h0);
    sys_rst = 1'b0;
    rd(5'h0C, d); check("rst.status", d, 32'h0);

    // Basic 3-byte read
    s0 = n_start; e0 = n_end;
    wr(5'h04, 32'h0001_2345);
    wr(5'h08, 32'd3);
    wr(5'h00, 32'h1);
    check("t1.spi_start", 32'(spi_start), 32'h1);
    check("t1.data_send0", 32'(data_send), 32'(EXP_OP));
    send_header("t1", 24'h012345);
    pulse_rec(8'hA1, s); check("t1.rx0_send", 32'(s), 32'h00);
    pulse_rec(8'hB2, s); check("t1.rx1_send", 32'(s), 32'h00);
    psel = 1'b1; paddr = 5'h0C;
    pulse_rec(8'hC3, s); check("t1.rx2_send", 32'(s), 32'h00);
    check("t1.spi_end", 32'(spi_end), 32'h1);
    check("t1.status_fin", prdata, 32'h0000_0303);
    psel = 1'b0;
    idle(3);
    check("t1.n_start", 32'(n_start - s0), 32'd1);
    check("t1.n_end",   32'(n_end - e0),   32'd1);
    rd(5'h0C, d); check("t1.status", d, 32'h0000_0302);
    rd(5'h10, d); check("t1.rd0", d, 32'hA1);
    rd(5'h10, d); check("t1.rd1", d, 32'hB2);
    rd(5'h10, d); check("t1.rd2", d, 32'hC3);
    rd(5'h10, d); check("t1.rd_empty", d, 32'h0);

    // LEN=0: DONE one cycle after START, no SPI activity
    wr(5'h00, 32'h2);
    rd(5'h0C, d); check("t2.clr_status", d, 32'h0);
    s0 = n_start;
    wr(5'h08, 32'd0);
    wr(5'h00, 32'h1);
    peek(5'h0C, d); check("t2.done", d, 32'h0000_0002);
    check("t2.spi_start", 32'(spi_start), 32'h0);
    idle(4);
    check("t2.n_start", 32'(n_start - s0), 32'd0);

    // Overflow: 20 bytes into a 16-entry FIFO
    e0 = n_end;
    wr(5'h04, 32'h000A_0B0C);
    wr(5'h08, 32'd20);
    wr(5'h00, 32'h3);
    send_header("t3", 24'h0A0B0C);
    for (int i = 0; i < 20; i++) pulse_rec(8'(8'h40 + i), s);
    check("t3.spi_end", 32'(spi_end), 32'h1);
    idle(1);
    check("t3.n_end", 32'(n_end - e0), 32'd1);
    rd(5'h0C, d); check("t3.status", d, 32'h0000_1006);
    rd(5'h10, d); check("t3.rd0", d, 32'h40);
    rd(5'h0C, d); check("t3.status_pop", d, 32'h0000_0F06);

    // Unmapped / unaligned writes are rejected and ignored
    apb_write(5'h14, 32'hFFFF_FFFF, e); check("t4.err_14", 32'(e), 32'h1);
    apb_write(5'h06, 32'hFFFF_FFFF, e); check("t4.err_06", 32'(e), 32'h1);
    rd(5'h0C, d); check("t4.status", d, 32'h0000_0F06);
    rd(5'h04, d); check("t4.addr", d, 32'h000A_0B0C);
    rd(5'h08, d); check("t4.len", d, 32'd20);
    apb_write(5'h08, 32'd2, e); check("t4.err_ok", 32'(e), 32'h0);

    // CLR+START with OVF set: flush and clear before the new transfer
    wr(5'h00, 32'h3);
    peek(5'h0C, d); check("t6.status_start", d, 32'h0000_0001);
    send_header("t6", 24'h0A0B0C);
    pulse_rec(8'h11, s);
    pulse_rec(8'h22, s);
    idle(2);
    rd(5'h10, d); check("t6.rd0", d, 32'h11);
    rd(5'h10, d); check("t6.rd1", d, 32'h22);
    rd(5'h0C, d); check("t6.status", d, 32'h0000_0002);

    // START and ADDR writes during BUSY (at AD1) are ignored
    s0 = n_start; e0 = n_end;
    wr(5'h04, 32'h00C0_FFEE);
    wr(5'h08, 32'd1);
    wr(5'h00, 32'h1);
    pulse_send(s); check("t5.op", 32'(s), 32'(EXP_OP));
    pulse_send(s); check("t5.ad2", 32'(s), 32'hC0);
    wr(5'h04, 32'h0012_3456);
    wr(5'h00, 32'h1);
    pulse_send(s); check("t5.ad1", 32'(s), 32'hFF);
    pulse_send(s); check("t5.ad0", 32'(s), 32'hEE);
`ifdef FAST_READ_EN
    pulse_send(s);
`endif
    pulse_rec(8'h77, s);
    check("t5.spi_end", 32'(spi_end), 32'h1);
    idle(5);
    check("t5.n_start", 32'(n_start - s0), 32'd1);
    check("t5.n_end",   32'(n_end - e0),   32'd1);
    rd(5'h04, d); check("t5.addr", d, 32'h00C0_FFEE);
    rd(5'h0C, d); check("t5.status", d, 32'h0000_0102);
    rd(5'h10, d); check("t5.rd0", d, 32'h77);

    // Reset during READ after two bytes, then a fresh transfer
    e0 = n_end;
    wr(5'h08, 32'd4);
    wr(5'h00, 32'h3);
    send_header("t7", 24'hC0FFEE);
    pulse_rec(8'h01, s);
    pulse_rec(8'h02, s);
    sys_rst = 1'b1;
    peek(5'h0C, d); check("t7.status_rst", d, 32'h0);
    check("t7.spi_end_rst", 32'(spi_end), 32'h0);
    check("t7.data_send_rst", 32'(data_send), 32'h0);
    idle(2);
    sys_rst = 1'b0;
    idle(3);
    check("t7.n_end", 32'(n_end - e0), 32'd0);
    wr(5'h08, 32'd1);
    wr(5'h00, 32'h1);
    check("t7.spi_start", 32'(spi_start), 32'h1);
    send_header("t7b", 24'h000000);
    pulse_rec(8'h5A, s);
    check("t7.spi_end", 32'(spi_end), 32'h1);
    idle(2);
    rd(5'h10, d); check("t7.rd0", d, 32'h5A);
    rd(5'h0C, d); check("t7.status", d, 32'h0000_0002);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
